// File: rtl/beamformer_controller.sv
`default_nettype none
// ============================================================================
//  Module   : beamformer_controller
//  Purpose  : Sequences one beamforming pass: load-in, filtering into the
//             filtered-signal BRAM, filter drain, slice-based beamforming
//             driven by the core's data-consumed flag, and sum readout.
//  Revision : 1.0 - initial release
// ============================================================================
module beamformer_controller #(
  parameter int SIG_DEPTH    = 2048,
  parameter int SUM_DEPTH    = 540,
  parameter int FLUSH_CYCLES = 6,
  parameter int LOAD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        valid_out,
  input  logic        usedataflag,
  output logic        bf_rst,
  output logic        signalinen,
  output logic        start,
  output logic [10:0] signal_address,
  output logic [10:0] readin_address,
  output logic        filter_bram_output_write_en,
  output logic        startbeamformer,
  output logic        output_read_en,
  output logic [1:0]  slice_state,
  output logic [15:0] sample_index,
  output logic [9:0]  sumout_address,
  output logic        sumouten,
  output logic        busy,
  output logic        done
);

  // State encoding
  localparam logic [2:0] c_ST_IDLE         = 3'd0;
  localparam logic [2:0] c_ST_LOADIN       = 3'd1;
  localparam logic [2:0] c_ST_FILTERING    = 3'd2;
  localparam logic [2:0] c_ST_FINISHFILTER = 3'd3;
  localparam logic [2:0] c_ST_BEAMFORMING  = 3'd4;
  localparam logic [2:0] c_ST_SUMMING      = 3'd5;
  localparam logic [2:0] c_ST_DONE         = 3'd6;

  // Counter widths and terminal counts
  localparam int c_LOAD_W  = (LOAD_CYCLES  > 1) ? $clog2(LOAD_CYCLES)  : 1;
  localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_LOAD_W-1:0]  c_LOAD_LAST   = c_LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST  = c_FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [10:0]          c_SIG_LAST    = 11'(SIG_DEPTH - 1);
  localparam logic [9:0]           c_SUM_LAST    = 10'(SUM_DEPTH - 1);
  // Sample index starts two behind zero so the first slice-1/2 steps land on 0
  localparam logic [15:0]          c_SAMPLE_INIT = 16'hFFFE;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;

  logic [c_LOAD_W-1:0]  r_load_cnt;
  logic [c_FLUSH_W-1:0] r_flush_cnt;
  logic [10:0]          r_signal_address;
  logic [10:0]          r_readin_address;
  logic [9:0]           r_sumout_address;
  logic [1:0]           r_slice_state;
  logic [15:0]          r_sample_index;
  logic                 r_udf;
  logic                 w_udf_fall;

  logic                 r_bf_rst, r_signalinen, r_start, r_startbeamformer;
  logic                 r_output_read_en, r_sumouten, r_busy, r_done;
  logic                 w_bf_rst_nxt, w_signalinen_nxt, w_start_nxt;
  logic                 w_startbeamformer_nxt, w_output_read_en_nxt;
  logic                 w_sumouten_nxt, w_busy_nxt, w_done_nxt;
  logic                 w_filter_phase;

  // Falling edge of the consumed flag: last registered sample high, now low
  assign w_udf_fall = r_udf & ~usedataflag;

  // Filtered-BRAM write window covers filtering and the drain
  assign w_filter_phase = (r_state == c_ST_FILTERING) || (r_state == c_ST_FINISHFILTER);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:         if (go) w_state_nxt = c_ST_LOADIN;
      c_ST_LOADIN:       if (r_load_cnt == c_LOAD_LAST) w_state_nxt = c_ST_FILTERING;
      c_ST_FILTERING:    if (r_signal_address == c_SIG_LAST) w_state_nxt = c_ST_FINISHFILTER;
      c_ST_FINISHFILTER: if (r_flush_cnt == c_FLUSH_LAST) w_state_nxt = c_ST_BEAMFORMING;
      c_ST_BEAMFORMING:  if (w_udf_fall && (r_sumout_address == c_SUM_LAST))
                           w_state_nxt = c_ST_SUMMING;
      c_ST_SUMMING:      if (r_sumout_address == c_SUM_LAST) w_state_nxt = c_ST_DONE;
      c_ST_DONE:         if (go) w_state_nxt = c_ST_LOADIN;
      default:           w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags can be registered
  always_comb begin
    w_bf_rst_nxt          = 1'b0;
    w_signalinen_nxt      = 1'b0;
    w_start_nxt           = 1'b0;
    w_startbeamformer_nxt = 1'b0;
    w_output_read_en_nxt  = 1'b0;
    w_sumouten_nxt        = 1'b0;
    w_busy_nxt            = 1'b1;
    w_done_nxt            = 1'b0;
    case (w_state_nxt)
      c_ST_LOADIN: begin
        w_bf_rst_nxt     = 1'b1;
        w_signalinen_nxt = 1'b1;
      end
      c_ST_FILTERING, c_ST_FINISHFILTER: begin
        w_bf_rst_nxt = 1'b1;
        w_start_nxt  = 1'b1;
      end
      c_ST_BEAMFORMING: begin
        w_startbeamformer_nxt = 1'b1;
        w_output_read_en_nxt  = 1'b1;
      end
      c_ST_SUMMING:   w_sumouten_nxt = 1'b1;
      c_ST_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default:        w_busy_nxt = 1'b0;
    endcase
  end

  // Registered control flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bf_rst          <= 1'b0;
      r_signalinen      <= 1'b0;
      r_start           <= 1'b0;
      r_startbeamformer <= 1'b0;
      r_output_read_en  <= 1'b0;
      r_sumouten        <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_bf_rst          <= w_bf_rst_nxt;
      r_signalinen      <= w_signalinen_nxt;
      r_start           <= w_start_nxt;
      r_startbeamformer <= w_startbeamformer_nxt;
      r_output_read_en  <= w_output_read_en_nxt;
      r_sumouten        <= w_sumouten_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
    end
  end

  // Address, slice and phase counters advanced according to the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_udf            <= 1'b0;
      r_load_cnt       <= '0;
      r_flush_cnt      <= '0;
      r_signal_address <= '0;
      r_readin_address <= '0;
      r_sumout_address <= '0;
      r_slice_state    <= '0;
      r_sample_index   <= c_SAMPLE_INIT;
    end else begin
      r_udf <= usedataflag;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (go) begin
            r_load_cnt       <= '0;
            r_flush_cnt      <= '0;
            r_signal_address <= '0;
            r_readin_address <= '0;
            r_sumout_address <= '0;
            r_slice_state    <= '0;
            r_sample_index   <= c_SAMPLE_INIT;
          end
        end
        c_ST_LOADIN: begin
          r_load_cnt <= (r_load_cnt == c_LOAD_LAST) ? '0 : r_load_cnt + c_LOAD_W'(1);
        end
        c_ST_FILTERING: begin
          r_signal_address <= (r_signal_address == c_SIG_LAST) ? '0
                                                               : r_signal_address + 11'd1;
          if (valid_out) r_readin_address <= r_readin_address + 11'd1;
        end
        c_ST_FINISHFILTER: begin
          if (r_flush_cnt == c_FLUSH_LAST) begin
            // Drain complete: rewind the BRAM read pointer for beamforming
            r_flush_cnt      <= '0;
            r_readin_address <= '0;
            r_sample_index   <= c_SAMPLE_INIT;
            r_slice_state    <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + c_FLUSH_W'(1);
            if (valid_out) r_readin_address <= r_readin_address + 11'd1;
          end
        end
        c_ST_BEAMFORMING: begin
          r_slice_state <= r_slice_state + 2'd1;
          if (r_slice_state != 2'd0) r_sample_index <= r_sample_index + 16'd1;
          if (r_slice_state == 2'd3) r_readin_address <= r_readin_address + 11'd1;
          if (w_udf_fall)
            r_sumout_address <= (r_sumout_address == c_SUM_LAST) ? '0
                                                                 : r_sumout_address + 10'd1;
        end
        c_ST_SUMMING: begin
          r_sumout_address <= (r_sumout_address == c_SUM_LAST) ? '0
                                                               : r_sumout_address + 10'd1;
        end
        default: ;
      endcase
    end
  end

  assign bf_rst                      = r_bf_rst;
  assign signalinen                  = r_signalinen;
  assign start                       = r_start;
  assign signal_address              = r_signal_address;
  assign readin_address              = r_readin_address;
  assign filter_bram_output_write_en = valid_out & w_filter_phase;
  assign startbeamformer             = r_startbeamformer;
  assign output_read_en              = r_output_read_en;
  assign slice_state                 = r_slice_state;
  assign sample_index                = r_sample_index;
  assign sumout_address              = r_sumout_address;
  assign sumouten                    = r_sumouten;
  assign busy                        = r_busy;
  assign done                        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beamformer_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beamformer_controller
//  Purpose  : Randomized self-checking bench for beamformer_controller. The
//             reference model tracks elapsed cycles since the accepted run
//             request and derives every output from closed-form arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beamformer_controller;

  localparam int L   = 2;
  localparam int SD  = 2048;
  localparam int FL  = 6;
  localparam int SU  = 540;
  localparam int B   = L + SD + FL;      // cycles from run start to beamforming
  localparam int BIG = 32'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, go, valid_out, usedataflag;
  logic        bf_rst, signalinen, start, filter_bram_output_write_en;
  logic        startbeamformer, output_read_en, sumouten, busy, done;
  logic [10:0] signal_address, readin_address;
  logic [1:0]  slice_state;
  logic [15:0] sample_index;
  logic [9:0]  sumout_address;

  always #5 clk = ~clk;

  beamformer_controller #(
    .SIG_DEPTH(SD), .SUM_DEPTH(SU), .FLUSH_CYCLES(FL), .LOAD_CYCLES(L)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .valid_out(valid_out), .usedataflag(usedataflag),
    .bf_rst(bf_rst), .signalinen(signalinen), .start(start),
    .signal_address(signal_address), .readin_address(readin_address),
    .filter_bram_output_write_en(filter_bram_output_write_en),
    .startbeamformer(startbeamformer), .output_read_en(output_read_en),
    .slice_state(slice_state), .sample_index(sample_index),
    .sumout_address(sumout_address), .sumouten(sumouten), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_n = clock edges since the run request was accepted
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_S      = BIG;   // value of m_n at which the sum readout begins
  int m_fall   = 0;
  int m_valid  = 0;
  bit m_prev   = 1'b0;
  bit vforce   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Phase label from elapsed time: 0 idle,1 load,2 filter,3 drain,4 beam,5 sum,6 done
  function automatic int ph();
    if (!m_active)        return 0;
    if (m_n < L)          return 1;
    if (m_n < L + SD)     return 2;
    if (m_n < B)          return 3;
    if (m_n < m_S)        return 4;
    if (m_n < m_S + SU)   return 5;
    return 6;
  endfunction

  // Model update on each active edge
  initial forever begin
    int p;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0; m_n = 0; m_S = BIG; m_fall = 0; m_valid = 0; m_prev = 1'b0;
    end else begin
      p = ph();
      if ((p == 0 || p == 6) && go) begin
        m_active = 1'b1; m_n = 0; m_S = BIG; m_fall = 0; m_valid = 0;
      end else if (p != 0) begin
        if ((p == 2 || p == 3) && valid_out) m_valid++;
        if (p == 4 && m_prev && !usedataflag) begin
          m_fall++;
          if (m_fall == SU) m_S = m_n + 1;
        end
        m_n++;
      end
      m_prev = usedataflag;
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  initial forever begin
    int p, k, e_read, e_slice, e_sum, e_sig;
    logic [15:0] e_samp;
    @(negedge clk);
    p = ph();
    k = (p == 4) ? (m_n - B) : ((p >= 5) ? (m_S - B) : 0);
    e_sig = (p == 2) ? (m_n - L) : 0;
    if (p == 2 || p == 3) e_read = m_valid % 2048;
    else if (p >= 4)      e_read = (k / 4) % 2048;
    else                  e_read = 0;
    e_slice = (p >= 4) ? (k % 4) : 0;
    e_samp  = (p >= 4) ? 16'(32'hFFFE + k - (k + 3) / 4) : 16'hFFFE;
    e_sum   = (p == 4) ? m_fall : ((p == 5) ? (m_n - m_S) : 0);
    chk("bf_rst",          int'(bf_rst),          int'(p >= 1 && p <= 3));
    chk("signalinen",      int'(signalinen),      int'(p == 1));
    chk("start",           int'(start),           int'(p == 2 || p == 3));
    chk("write_en",        int'(filter_bram_output_write_en),
                           int'((p == 2 || p == 3) && valid_out));
    chk("signal_address",  int'(signal_address),  e_sig);
    chk("readin_address",  int'(readin_address),  e_read);
    chk("startbeamformer", int'(startbeamformer), int'(p == 4));
    chk("output_read_en",  int'(output_read_en),  int'(p == 4));
    chk("slice_state",     int'(slice_state),     e_slice);
    chk("sample_index",    int'(sample_index),    int'(e_samp));
    chk("sumout_address",  int'(sumout_address),  e_sum);
    chk("sumouten",        int'(sumouten),        int'(p == 5));
    chk("busy",            int'(busy),            int'(p >= 1 && p <= 5));
    chk("done",            int'(done),            int'(p == 6));
  end

  // One stimulus step: inputs change 1 time unit after the falling edge
  task automatic tick(input int gomode);
    @(negedge clk); #1;
    usedataflag = 1'($urandom_range(0, 1));
    if (vforce && ph() == 2 && (m_n - L) < 10) valid_out = 1'b1;
    else                                       valid_out = 1'($urandom_range(0, 1));
    case (gomode)
      0:       go = 1'b0;
      1:       go = 1'b1;
      default: go = (ph() >= 1 && ph() <= 5) ? ($urandom_range(0, 3) == 0) : 1'b0;
    endcase
  endtask

  // Step until a DUT output rises, with a cycle budget
  task automatic wait_for(input string name, input int sel, input int budget);
    int i;
    logic s;
    i = 0;
    forever begin
      case (sel)
        0:       s = startbeamformer;
        1:       s = sumouten;
        default: s = done;
      endcase
      if (s || i >= budget) break;
      tick(2);
      i++;
    end
    chk(name, int'(s), 1);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; valid_out = 1'b0; usedataflag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample_index", int'(sample_index), 16'hFFFE);
    chk("rst_busy", int'(busy), 0);
    #1 rst = 1'b0;
    repeat (20) tick(0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_sample_index", int'(sample_index), 16'hFFFE);
    chk("idle_signalinen", int'(signalinen), 0);

    // Run 1: full pass with hand-computed landmarks
    vforce = 1'b1;
    tick(1); tick(0);
    chk("load0_signalinen", int'(signalinen), 1);
    chk("load0_bf_rst", int'(bf_rst), 1);
    chk("load0_start", int'(start), 0);
    tick(0);
    chk("load1_signalinen", int'(signalinen), 1);
    tick(0);
    chk("filt0_start", int'(start), 1);
    chk("filt0_signalinen", int'(signalinen), 0);
    chk("filt0_signal_address", int'(signal_address), 0);
    repeat (10) tick(2);
    chk("filt10_readin_address", int'(readin_address), 10);
    chk("filt10_signal_address", int'(signal_address), 10);
    vforce = 1'b0;
    repeat (SD - 11) tick(2);
    chk("filt_last_signal_address", int'(signal_address), 2047);
    tick(2);
    chk("flush_signal_address", int'(signal_address), 0);
    chk("flush_start", int'(start), 1);
    wait_for("reach_beamforming", 0, 20);
    chk("bf0_slice", int'(slice_state), 0);
    chk("bf0_sample_index", int'(sample_index), 16'hFFFE);
    chk("bf0_readin", int'(readin_address), 0);
    chk("bf0_bf_rst", int'(bf_rst), 0);
    repeat (8) tick(2);
    chk("bf8_slice", int'(slice_state), 0);
    chk("bf8_sample_index", int'(sample_index), 16'h0004);
    chk("bf8_readin", int'(readin_address), 2);
    wait_for("reach_summing", 1, 8000);
    chk("sum0_sumout_address", int'(sumout_address), 0);
    chk("sum0_startbeamformer", int'(startbeamformer), 0);
    wait_for("reach_done", 2, 600);
    chk("done_busy", int'(busy), 0);
    chk("done_sumouten", int'(sumouten), 0);
    repeat (5) tick(0);

    // Run 2: restart from DONE, reset in the middle of beamforming
    tick(1); tick(0);
    chk("restart_signalinen", int'(signalinen), 1);
    chk("restart_readin", int'(readin_address), 0);
    wait_for("reach_beamforming2", 0, 2200);
    repeat ($urandom_range(5, 300)) tick(2);
    @(negedge clk); #1;
    go = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_startbeamformer", int'(startbeamformer), 0);
    chk("midrst_output_read_en", int'(output_read_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_slice", int'(slice_state), 0);
    chk("midrst_sample_index", int'(sample_index), 16'hFFFE);
    chk("midrst_readin", int'(readin_address), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (10) tick(0);
    chk("postrst_busy", int'(busy), 0);

    // Run 3: restart from IDLE after reset, full random pass
    tick(1); tick(0);
    chk("run3_signalinen", int'(signalinen), 1);
    wait_for("run3_done", 2, 9000);
    repeat (4) tick(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
